sc_reg_serial_reader: RTL and testbench
=======================================

Name: sc_reg_serial_reader

Overview:
Parallel-to-serial reader for the general-purpose register bank. It captures a word from a register's data output bus on an active-low load strobe, then shifts the word out MSB-first over a valid/ready serial handshake. It sits between the register bank and serial consumers such as the debug/UART path, and is the read-out counterpart of the register write path.

Parameters:
DATAWIDTH_BUS, 32, width of the captured word and of the shift register (must be >= 2).

Ports:
SC_RegSERIAL_CLOCK_50  input  1  system clock; all state updates on the falling edge, same edge as the register bank.
SC_RegSERIAL_RESET_InHigh  input  1  synchronous active-high reset, sampled on the falling clock edge.
SC_RegSERIAL_Load_InLow  input  1  active-low load strobe; captures the data bus when idle.
SC_RegSERIAL_DataBUS_In  input  DATAWIDTH_BUS  parallel word, normally a register's data output bus.
SC_RegSERIAL_Ready_InHigh  input  1  consumer ready; a bit is consumed on an edge where Valid=1 and Ready=1.
SC_RegSERIAL_Serial_Out  output  1  current serial bit, MSB first.
SC_RegSERIAL_SerialValid_Out  output  1  Serial_Out holds a valid bit.
SC_RegSERIAL_Busy_Out  output  1  high in SHIFT and DONE; load strobes are ignored while high.
SC_RegSERIAL_Done_Out  output  1  one-cycle pulse after the last bit is consumed.

Behaviour:
- Clock and reset: one clock (SC_RegSERIAL_CLOCK_50, falling edge). Reset is synchronous and active-high.
- Reset: if RESET_InHigh=1 at a falling edge, then state=IDLE, shift register=0, bit counter=0, and Serial_Out=0, SerialValid_Out=0, Busy_Out=0, Done_Out=0. Reset has priority over every other input, including mid-shift; a word being shifted is discarded and no Done pulse is issued.
- All outputs are registered; there is no combinational path from any input to any output.
- FSM states are IDLE, SHIFT and DONE.
- IDLE:
  - Outputs Valid=0, Busy=0, Done=0.
  - If Load_InLow=0 at an edge: shift register <= DataBUS_In; counter <= DATAWIDTH_BUS-1; state <= SHIFT.
  - In the same edge: Serial_Out <= DataBUS_In[MSB], Valid <= 1, Busy <= 1.
  - Latency: the first bit is visible 1 cycle after the load edge.
- SHIFT:
  - On an edge with Ready=1 and counter>0: shift left by one (LSB filled with 0), Serial_Out <= next bit, counter decrements.
  - On an edge with Ready=1 and counter=0 (last bit consumed): state <= DONE, Valid <= 0, Done <= 1, Serial_Out <= 0.
  - On an edge with Ready=0: hold everything, with Serial_Out and Valid stable (backpressure for any number of cycles).
- DONE: lasts exactly one cycle with Done=1 and Busy=1. The next edge goes to IDLE with Done <= 0 and Busy <= 0.
- Load while busy: Load_InLow=0 in SHIFT or DONE is ignored. There is no queueing and the data in flight is not corrupted.
- Back-to-back words: the earliest next load is accepted on the edge after DONE (in IDLE). Minimum word period is DATAWIDTH_BUS+2 cycles with Ready held at 1.
- DataBUS_In is sampled only on the load edge. Later changes on the bus have no effect on the word being shifted.
- Held load strobe: Load_InLow held low continuously re-triggers a load on each IDLE entry. This is legal and intended for streaming a register.
- Bit count: exactly DATAWIDTH_BUS bits are presented per load, order MSB to LSB, with no extra or missing bits regardless of the Ready pattern.

Test Plan:
- Reset during idle and during SHIFT (DATAWIDTH_BUS=8, reset asserted after 3 bits) -> at the next edge all outputs are 0 and state is IDLE; no Done pulse; the next load of 8'h3C behaves normally.
- Basic shift, DATAWIDTH_BUS=8, Ready=1, load 8'hA5 -> Serial_Out sequence 1,0,1,0,0,1,0,1 on 8 consecutive cycles with Valid=1; then Done=1 for exactly one cycle; Busy high for 9 cycles.
- Backpressure: load 8'hC3, drop Ready for 3 cycles after the 2nd bit -> bit 3 (0) is held stable with Valid=1 for 4 cycles; the full sequence 1,1,0,0,0,0,1,1 is recovered; Done appears 3 cycles later than in the unstalled case.
- Load while busy: load 8'hF0, then pulse Load_InLow=0 with DataBUS_In=8'h0F during SHIFT and during DONE -> output is 1,1,1,1,0,0,0,0 only, and no second word is emitted.
- Bus change after load: load 8'h81, then change DataBUS_In to 8'h7E on the next cycle -> output is still 1,0,0,0,0,0,0,1.
- Streaming: Load_InLow held low with DataBUS_In=8'h55 and Ready=1 -> words are emitted back-to-back with a 10-cycle period; Done pulses every 10 cycles; Valid is low for exactly 2 cycles between words.

Source files
------------

// File: rtl/sc_reg_serial_reader_if.sv
// sc_reg_serial_reader_if: load strobe, parallel bus and serial valid/ready lines of the serial reader.
interface sc_reg_serial_reader_if #(parameter int DATAWIDTH_BUS = 32);
    logic                     SC_RegSERIAL_Load_InLow;
    logic [DATAWIDTH_BUS-1:0] SC_RegSERIAL_DataBUS_In;
    logic                     SC_RegSERIAL_Ready_InHigh;
    logic                     SC_RegSERIAL_Serial_Out;
    logic                     SC_RegSERIAL_SerialValid_Out;
    logic                     SC_RegSERIAL_Busy_Out;
    logic                     SC_RegSERIAL_Done_Out;
    modport slave (
        input  SC_RegSERIAL_Load_InLow, SC_RegSERIAL_DataBUS_In, SC_RegSERIAL_Ready_InHigh,
        output SC_RegSERIAL_Serial_Out, SC_RegSERIAL_SerialValid_Out, SC_RegSERIAL_Busy_Out,
               SC_RegSERIAL_Done_Out
    );
    modport master (
        output SC_RegSERIAL_Load_InLow, SC_RegSERIAL_DataBUS_In, SC_RegSERIAL_Ready_InHigh,
        input  SC_RegSERIAL_Serial_Out, SC_RegSERIAL_SerialValid_Out, SC_RegSERIAL_Busy_Out,
               SC_RegSERIAL_Done_Out
    );
endinterface

// File: rtl/sc_reg_serial_reader.sv
// sc_reg_serial_reader: captures a register word on an active-low load and shifts it out MSB-first over valid/ready.
module sc_reg_serial_reader #(parameter int DATAWIDTH_BUS = 32) (
    input logic               SC_RegSERIAL_CLOCK_50,
    input logic               SC_RegSERIAL_RESET_InHigh,
    sc_reg_serial_reader_if.slave bus
);
    localparam int CW = $clog2(DATAWIDTH_BUS);
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_e;
    state_e                   state_q;
    logic [DATAWIDTH_BUS-1:0] shift_q;
    logic [CW-1:0]            cnt_q;
    logic                     valid_q, busy_q, done_q;
    // The serial bit is the shift register MSB; the final shift empties it so the line drops to 0 in DONE.
    assign bus.SC_RegSERIAL_Serial_Out      = shift_q[DATAWIDTH_BUS-1];
    assign bus.SC_RegSERIAL_SerialValid_Out = valid_q;
    assign bus.SC_RegSERIAL_Busy_Out        = busy_q;
    assign bus.SC_RegSERIAL_Done_Out        = done_q;
    always_ff @(negedge SC_RegSERIAL_CLOCK_50) begin
        if (SC_RegSERIAL_RESET_InHigh) begin
            state_q <= IDLE;
            shift_q <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (!bus.SC_RegSERIAL_Load_InLow) begin
                    shift_q <= bus.SC_RegSERIAL_DataBUS_In;
                    cnt_q   <= CW'(DATAWIDTH_BUS - 1);
                    valid_q <= 1'b1;
                    busy_q  <= 1'b1;
                    state_q <= SHIFT;
                end
                SHIFT: if (bus.SC_RegSERIAL_Ready_InHigh) begin
                    shift_q <= {shift_q[DATAWIDTH_BUS-2:0], 1'b0};
                    cnt_q   <= cnt_q - 1'b1;
                    if (cnt_q == '0) begin
                        valid_q <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sc_reg_serial_reader.sv
// tb_sc_reg_serial_reader: directed and random checks of the serial reader against a bit-queue reference model.
module tb_sc_reg_serial_reader;
    localparam int W = 8;
    logic clk = 1'b0;
    logic rst;
    int n_assert = 0, n_fail = 0, cyc_n = 0, ndone = 0, nbusy = 0, got_n = 0, start;
    logic [W-1:0] got_w;
    int dq[$];
    bit mq[$];
    bit done_m;
    sc_reg_serial_reader_if #(.DATAWIDTH_BUS(W)) bus();
    sc_reg_serial_reader #(.DATAWIDTH_BUS(W)) dut (
        .SC_RegSERIAL_CLOCK_50(clk),
        .SC_RegSERIAL_RESET_InHigh(rst),
        .bus(bus)
    );
    always #10 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clr();
        got_n = 0; got_w = '0; ndone = 0; nbusy = 0; dq.delete(); start = cyc_n;
    endtask

    // Model: a word is a queue of bits still to present; one idle-less DONE cycle follows the last pop.
    task automatic cyc(input logic r, input logic ld, input logic [W-1:0] d, input logic rdy);
        rst = r;
        bus.SC_RegSERIAL_Load_InLow   = ld;
        bus.SC_RegSERIAL_DataBUS_In   = d;
        bus.SC_RegSERIAL_Ready_InHigh = rdy;
        if (!r && bus.SC_RegSERIAL_SerialValid_Out && rdy) begin
            got_w = {got_w[W-2:0], bus.SC_RegSERIAL_Serial_Out};
            got_n++;
        end
        if (r) begin
            mq.delete(); done_m = 0;
        end else if (done_m) begin
            done_m = 0;
        end else if (mq.size() > 0) begin
            if (rdy) begin
                void'(mq.pop_front());
                if (mq.size() == 0) done_m = 1;
            end
        end else if (!ld) begin
            for (int i = W - 1; i >= 0; i--) mq.push_back(d[i]);
        end
        @(negedge clk);
        @(posedge clk);
        #1;
        cyc_n++;
        if (bus.SC_RegSERIAL_Done_Out) begin ndone++; dq.push_back(cyc_n); end
        if (bus.SC_RegSERIAL_Busy_Out) nbusy++;
        chk("serial", 32'(bus.SC_RegSERIAL_Serial_Out), 32'(mq.size() > 0 ? mq[0] : 1'b0));
        chk("valid", 32'(bus.SC_RegSERIAL_SerialValid_Out), 32'(mq.size() > 0));
        chk("busy", 32'(bus.SC_RegSERIAL_Busy_Out), 32'(mq.size() > 0 || done_m));
        chk("done", 32'(bus.SC_RegSERIAL_Done_Out), 32'(done_m));
    endtask

    task automatic run_word(input logic [W-1:0] d);
        cyc(0, 0, d, 1);
        for (int i = 0; i < 20 && ndone == 0; i++) cyc(0, 1, ~d, 1);
        cyc(0, 1, d, 1);
    endtask

    initial begin
        done_m = 0;
        cyc(1, 1, 8'h00, 0);
        cyc(1, 0, 8'hFF, 1);
        chk("reset_serial", 32'(bus.SC_RegSERIAL_Serial_Out), 0);
        // basic A5
        clr();
        run_word(8'hA5);
        chk("basic_word", 32'(got_w), 32'hA5);
        chk("basic_nbits", got_n, 8);
        chk("basic_ndone", ndone, 1);
        chk("basic_busy_cycles", nbusy, 9);
        chk("basic_done_latency", dq[0] - start, 9);
        // backpressure C3
        clr();
        cyc(0, 0, 8'hC3, 1);
        cyc(0, 1, 8'h00, 1);
        cyc(0, 1, 8'h00, 1);
        repeat (3) cyc(0, 1, 8'h00, 0);
        for (int i = 0; i < 20 && ndone == 0; i++) cyc(0, 1, 8'h00, 1);
        cyc(0, 1, 8'h00, 1);
        chk("bp_word", 32'(got_w), 32'hC3);
        chk("bp_nbits", got_n, 8);
        chk("bp_done_latency", dq.size() > 0 ? dq[0] - start : -1, 12);
        // load while busy
        clr();
        cyc(0, 0, 8'hF0, 1);
        for (int i = 1; i <= 14; i++) cyc(0, !(i == 4 || i == 9), 8'h0F, 1);
        chk("busy_word", 32'(got_w), 32'hF0);
        chk("busy_nbits", got_n, 8);
        chk("busy_ndone", ndone, 1);
        // bus change after load
        clr();
        cyc(0, 0, 8'h81, 1);
        repeat (10) cyc(0, 1, 8'h7E, 1);
        chk("buschg_word", 32'(got_w), 32'h81);
        chk("buschg_nbits", got_n, 8);
        // reset mid-shift then normal load
        clr();
        cyc(0, 0, 8'hA5, 1);
        repeat (3) cyc(0, 1, 8'h00, 1);
        cyc(1, 1, 8'h00, 1);
        repeat (3) cyc(0, 1, 8'h00, 1);
        chk("rstmid_ndone", ndone, 0);
        chk("rstmid_nbits", got_n, 3);
        clr();
        run_word(8'h3C);
        chk("rstmid_next_word", 32'(got_w), 32'h3C);
        // streaming 55 with load held low
        clr();
        repeat (30) cyc(0, 0, 8'h55, 1);
        cyc(0, 1, 8'h55, 1);
        chk("stream_ndone", ndone, 3);
        chk("stream_nbits", got_n, 24);
        chk("stream_period1", dq.size() > 1 ? dq[1] - dq[0] : -1, 10);
        chk("stream_period2", dq.size() > 2 ? dq[2] - dq[1] : -1, 10);
        repeat (12) cyc(0, 1, 8'h00, 1);
        // random traffic
        for (int i = 0; i < 500; i++)
            cyc($urandom_range(99) == 0, $urandom_range(3) != 0, W'($urandom), $urandom_range(3) != 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
